// File: rtl/xcorr_pkg.sv
// Shared types and defaults for the xcorr detection chain.
package xcorr_pkg;

    localparam int unsigned MAG_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        HOLDOFF = 2'd2
    } peak_state_t;

endpackage

// File: rtl/xcorr_peak_track.sv
// Running max/argmax register pair; strict-greater update keeps the earliest of equal peaks.
module xcorr_peak_track #(
    parameter int unsigned MAG_W = 24,
    parameter int unsigned POS_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             update_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic [POS_W-1:0] pos_i,
    output logic [MAG_W-1:0] nxt_mag_o,
    output logic [POS_W-1:0] nxt_pos_o
);

    logic [MAG_W-1:0] max_q;
    logic [POS_W-1:0] max_pos_q;

    // Next values are exported so a window's final sample can be folded into the reported peak.
    always_comb begin
        nxt_mag_o = max_q;
        nxt_pos_o = max_pos_q;
        if (clear_i) begin
            nxt_mag_o = '0;
            nxt_pos_o = '0;
        end else if (load_i) begin
            nxt_mag_o = mag_i;
            nxt_pos_o = pos_i;
        end else if (update_i && (mag_i > max_q)) begin
            nxt_mag_o = mag_i;
            nxt_pos_o = pos_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_q     <= '0;
            max_pos_q <= '0;
        end else begin
            max_q     <= nxt_mag_o;
            max_pos_q <= nxt_pos_o;
        end
    end

endmodule

// File: rtl/xcorr_peak_dtct.sv
// Threshold crossing starts a WIN_LEN-sample peak search, ending in a one-cycle sop with peak data.
// Build option XCORR_PEAK_HOLDOFF_EN adds a HOLDOFF_LEN-sample dead time after each detection.
//   state   | meaning
//   IDLE    | waiting for corr_mag > thr_lvl
//   SEARCH  | tracking max over the window
//   HOLDOFF | ignoring samples after a detection
module xcorr_peak_dtct
    import xcorr_pkg::*;
#(
    parameter int unsigned MAG_W       = MAG_W_DEFAULT,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned HOLDOFF_LEN = 1024,
    parameter int unsigned POS_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             corr_valid,
    input  logic [MAG_W-1:0] corr_mag,
    input  logic [MAG_W-1:0] thr_lvl,
    output logic             sop,
    output logic [MAG_W-1:0] peak_mag,
    output logic [POS_W-1:0] peak_pos,
    output logic             busy,
    output logic [MAG_W-1:0] thr_dbg
);

    localparam int unsigned WIN_W = $clog2(WIN_LEN + 1);

    if (WIN_LEN < 1 || HOLDOFF_LEN < 1) begin : g_bad_len
        $error("xcorr_peak_dtct: WIN_LEN and HOLDOFF_LEN must be at least 1");
    end

    peak_state_t      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [MAG_W-1:0] thr_q, thr_d;
    logic             sop_q, sop_d;
    logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
    logic [POS_W-1:0] peak_pos_q, peak_pos_d;
    logic             busy_q, busy_d;
    logic             trk_clear, trk_load, trk_update, win_done;
    logic [MAG_W-1:0] trk_mag;
    logic [POS_W-1:0] trk_pos;

`ifdef XCORR_PEAK_HOLDOFF_EN
    localparam int unsigned HO_W = $clog2(HOLDOFF_LEN + 1);
    logic [HO_W-1:0] ho_q, ho_d;
`endif

    xcorr_peak_track #(
        .MAG_W (MAG_W),
        .POS_W (POS_W)
    ) u_track (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (trk_clear),
        .load_i    (trk_load),
        .update_i  (trk_update),
        .mag_i     (corr_mag),
        .pos_i     (pos_q),
        .nxt_mag_o (trk_mag),
        .nxt_pos_o (trk_pos)
    );

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        win_d      = win_q;
        thr_d      = thr_q;
        sop_d      = 1'b0;
        peak_mag_d = peak_mag_q;
        peak_pos_d = peak_pos_q;
        trk_clear  = 1'b0;
        trk_load   = 1'b0;
        trk_update = 1'b0;
        win_done   = 1'b0;
`ifdef XCORR_PEAK_HOLDOFF_EN
        ho_d       = ho_q;
`endif
        if (corr_valid) begin
            pos_d = pos_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (corr_mag > thr_lvl) begin
                        thr_d    = thr_lvl;
                        trk_load = 1'b1;
                        win_d    = WIN_W'(1);
                        win_done = (WIN_LEN == 1);
                        state_d  = SEARCH;
                    end else begin
                        trk_clear = 1'b1;
                    end
                end
                SEARCH: begin
                    trk_update = 1'b1;
                    win_d      = win_q + 1'b1;
                    win_done   = (win_d == WIN_W'(WIN_LEN));
                end
`ifdef XCORR_PEAK_HOLDOFF_EN
                HOLDOFF: begin
                    ho_d = ho_q + 1'b1;
                    if (ho_d == HO_W'(HOLDOFF_LEN)) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase

            // The tracker's next value already includes this cycle's sample.
            if (win_done) begin
                sop_d      = 1'b1;
                peak_mag_d = trk_mag;
                peak_pos_d = trk_pos;
`ifdef XCORR_PEAK_HOLDOFF_EN
                state_d    = HOLDOFF;
                ho_d       = '0;
`else
                state_d    = IDLE;
`endif
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            win_q      <= '0;
            thr_q      <= '0;
            sop_q      <= 1'b0;
            peak_mag_q <= '0;
            peak_pos_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            win_q      <= win_d;
            thr_q      <= thr_d;
            sop_q      <= sop_d;
            peak_mag_q <= peak_mag_d;
            peak_pos_q <= peak_pos_d;
            busy_q     <= busy_d;
        end
    end

`ifdef XCORR_PEAK_HOLDOFF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ho_q <= '0;
        end else begin
            ho_q <= ho_d;
        end
    end
`endif

    assign sop      = sop_q;
    assign peak_mag = peak_mag_q;
    assign peak_pos = peak_pos_q;
    assign busy     = busy_q;
    assign thr_dbg  = thr_q;

endmodule
